// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stall, memory-miss freeze, branch squash,
// EX operand forwarding select and a stall-length watchdog.
module hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int FWD_EN    = 1,
  parameter int MAX_STALL = 15,
  parameter int BR_FLUSH  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic              id_rs_use,
  input  logic              id_rt_use,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_valid,
  input  logic              ex_wr,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              mem_valid,
  input  logic              mem_wr,
  input  logic              mem_req,
  input  logic              mem_hit,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              wb_wr,
  input  logic              br_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [7:0]        stall_cnt,
  output logic              wdog
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);

  state_t            state_q, state_d;
  logic              br_held_q, br_held_d;
  logic [7:0]        stall_cnt_q, stall_cnt_d;
  logic              wdog_q, wdog_d;
  logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
  logic              ex_rs_use_q, ex_rs_use_d;
  logic              ex_rt_use_q, ex_rt_use_d;

  logic ex_prod, mem_prod, miss, raw_hz, any_stall;
  logic rs_ex, rt_ex, rs_mem, rt_mem;

  // Register 0 never produces a dependency.
  function automatic logic src_match(input logic use_bit, input logic prod_ok,
                                     input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst);
    return use_bit && prod_ok && (src != {REG_AW{1'b0}}) && (src == dst);
  endfunction

  assign ex_prod  = ex_valid && ex_wr;
  assign mem_prod = mem_valid && mem_wr;
  assign miss     = mem_req && !mem_hit;
  assign rs_ex    = src_match(id_rs_use, ex_prod, id_rs, ex_dst);
  assign rt_ex    = src_match(id_rt_use, ex_prod, id_rt, ex_dst);
  assign rs_mem   = src_match(id_rs_use, mem_prod, id_rs, mem_dst);
  assign rt_mem   = src_match(id_rt_use, mem_prod, id_rt, mem_dst);

  // Without forwarding every in-flight producer blocks decode; with it only a load in EX does.
  assign raw_hz = (FWD_EN != 0) ? (id_valid && ex_memread && (rs_ex || rt_ex))
                                : (id_valid && (rs_ex || rt_ex || rs_mem || rt_mem));

  always_comb begin
    state_d    = state_q;
    br_held_d  = br_held_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (state_q)
      RUN, LU_STALL: begin
        if (miss) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_en  = 1'b0;
          br_held_d = br_taken;
          state_d   = MEM_WAIT;
        end else if (br_taken) begin
          ifid_flush = 1'b1;
          idex_flush = (BR_FLUSH == 2);
          br_held_d  = 1'b0;
          state_d    = FLUSH;
        end else if (raw_hz && !((state_q == LU_STALL) && (FWD_EN != 0))) begin
          // With forwarding the bubble is exactly one cycle, so LU_STALL never re-stalls.
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          br_held_d  = 1'b0;
          state_d    = LU_STALL;
        end else begin
          br_held_d = 1'b0;
          state_d   = RUN;
        end
      end
      MEM_WAIT: begin
        if (!mem_hit) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_en  = 1'b0;
          br_held_d = br_held_q || br_taken;
        end else if (br_held_q || br_taken) begin
          ifid_flush = 1'b1;
          idex_flush = (BR_FLUSH == 2);
          br_held_d  = 1'b0;
          state_d    = FLUSH;
        end else begin
          br_held_d = 1'b0;
          state_d   = RUN;
        end
      end
      FLUSH: begin
        if (miss) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_en  = 1'b0;
          br_held_d = br_taken;
          state_d   = MEM_WAIT;
        end else begin
          br_held_d = 1'b0;
          state_d   = RUN;
        end
      end
      default: begin
        br_held_d = 1'b0;
        state_d   = RUN;
      end
    endcase
  end

  // Stall-length counter and sticky watchdog.
  always_comb begin
    any_stall = !(pc_en && ifid_en && idex_en && exmem_en);
    if (any_stall) begin
      if (stall_cnt_q == 8'hFF) begin
        stall_cnt_d = stall_cnt_q;
      end else begin
        stall_cnt_d = stall_cnt_q + 8'd1;
      end
    end else begin
      stall_cnt_d = 8'd0;
    end
    wdog_d = wdog_q || (stall_cnt_d >= MAX_STALL_C);
  end

  // Shadow of the ID/EX source fields so forwarding can look at the EX-stage operands.
  always_comb begin
    ex_rs_d     = ex_rs_q;
    ex_rt_d     = ex_rt_q;
    ex_rs_use_d = ex_rs_use_q;
    ex_rt_use_d = ex_rt_use_q;
    if (idex_en) begin
      if (idex_flush || !id_valid) begin
        ex_rs_d     = {REG_AW{1'b0}};
        ex_rt_d     = {REG_AW{1'b0}};
        ex_rs_use_d = 1'b0;
        ex_rt_use_d = 1'b0;
      end else begin
        ex_rs_d     = id_rs;
        ex_rt_d     = id_rt;
        ex_rs_use_d = id_rs_use;
        ex_rt_use_d = id_rt_use;
      end
    end else begin
      ex_rs_d     = ex_rs_q;
      ex_rt_d     = ex_rt_q;
      ex_rs_use_d = ex_rs_use_q;
      ex_rt_use_d = ex_rt_use_q;
    end
  end

  // Operand select: the younger producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      if (src_match(ex_rs_use_q, mem_prod, ex_rs_q, mem_dst)) begin
        fwd_a = 2'b01;
      end else if (src_match(ex_rs_use_q, wb_wr, ex_rs_q, wb_dst)) begin
        fwd_a = 2'b10;
      end else begin
        fwd_a = 2'b00;
      end
      if (src_match(ex_rt_use_q, mem_prod, ex_rt_q, mem_dst)) begin
        fwd_b = 2'b01;
      end else if (src_match(ex_rt_use_q, wb_wr, ex_rt_q, wb_dst)) begin
        fwd_b = 2'b10;
      end else begin
        fwd_b = 2'b00;
      end
    end else begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      br_held_q   <= 1'b0;
      stall_cnt_q <= 8'd0;
      wdog_q      <= 1'b0;
      ex_rs_q     <= {REG_AW{1'b0}};
      ex_rt_q     <= {REG_AW{1'b0}};
      ex_rs_use_q <= 1'b0;
      ex_rt_use_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      br_held_q   <= br_held_d;
      stall_cnt_q <= stall_cnt_d;
      wdog_q      <= wdog_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_rs_use_q <= ex_rs_use_d;
      ex_rt_use_q <= ex_rt_use_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign wdog      = wdog_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: default instance (forwarding, BR_FLUSH=2) and an
// alternate instance (no forwarding, BR_FLUSH=1) driven by the same stimulus.
module tb_hazard_ctrl;
  localparam int AW = 5;

  logic CLK = 1'b0;
  logic RST;
  logic id_valid, id_rs_use, id_rt_use;
  logic [AW-1:0] id_rs, id_rt;
  logic ex_valid, ex_wr, ex_memread;
  logic [AW-1:0] ex_dst;
  logic mem_valid, mem_wr, mem_req, mem_hit;
  logic [AW-1:0] mem_dst, wb_dst;
  logic wb_wr, br_taken;

  logic pc_en0, ifid_en0, idex_en0, exmem_en0, ifid_flush0, idex_flush0, wdog0;
  logic [1:0] fwd_a0, fwd_b0;
  logic [7:0] stall_cnt0;
  logic pc_en1, ifid_en1, idex_en1, exmem_en1, ifid_flush1, idex_flush1, wdog1;
  logic [1:0] fwd_a1, fwd_b1;
  logic [7:0] stall_cnt1;
  logic [18:0] obs0, obs1;

  typedef struct {
    string       name;
    bit          sel;
    logic [18:0] v;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLK = ~CLK;

  assign obs0 = {pc_en0, ifid_en0, idex_en0, exmem_en0, ifid_flush0, idex_flush0,
                 fwd_a0, fwd_b0, stall_cnt0, wdog0};
  assign obs1 = {pc_en1, ifid_en1, idex_en1, exmem_en1, ifid_flush1, idex_flush1,
                 fwd_a1, fwd_b1, stall_cnt1, wdog1};

  hazard_ctrl u_dut0 (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs_use(id_rs_use), .id_rt_use(id_rt_use),
    .id_rs(id_rs), .id_rt(id_rt), .ex_valid(ex_valid), .ex_wr(ex_wr), .ex_memread(ex_memread),
    .ex_dst(ex_dst), .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_req(mem_req),
    .mem_hit(mem_hit), .mem_dst(mem_dst), .wb_dst(wb_dst), .wb_wr(wb_wr), .br_taken(br_taken),
    .pc_en(pc_en0), .ifid_en(ifid_en0), .idex_en(idex_en0), .exmem_en(exmem_en0),
    .ifid_flush(ifid_flush0), .idex_flush(idex_flush0), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
    .stall_cnt(stall_cnt0), .wdog(wdog0)
  );

  hazard_ctrl #(.FWD_EN(0), .BR_FLUSH(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs_use(id_rs_use), .id_rt_use(id_rt_use),
    .id_rs(id_rs), .id_rt(id_rt), .ex_valid(ex_valid), .ex_wr(ex_wr), .ex_memread(ex_memread),
    .ex_dst(ex_dst), .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_req(mem_req),
    .mem_hit(mem_hit), .mem_dst(mem_dst), .wb_dst(wb_dst), .wb_wr(wb_wr), .br_taken(br_taken),
    .pc_en(pc_en1), .ifid_en(ifid_en1), .idex_en(idex_en1), .exmem_en(exmem_en1),
    .ifid_flush(ifid_flush1), .idex_flush(idex_flush1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
    .stall_cnt(stall_cnt1), .wdog(wdog1)
  );

  // Expected vector: {pc,ifid,idex,exmem}, {ifid_flush,idex_flush}, fwd_a, fwd_b, stall_cnt, wdog
  function automatic logic [18:0] mk(input logic [3:0] en, input logic [1:0] fl,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [7:0] cnt, input logic wd);
    return {en, fl, fa, fb, cnt, wd};
  endfunction

  task automatic push(input string nm, input bit sel, input logic [18:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.v    = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs_use = 1'b0; id_rt_use = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
    ex_valid = 1'b0; ex_wr = 1'b0; ex_memread = 1'b0; ex_dst = 5'd0;
    mem_valid = 1'b0; mem_wr = 1'b0; mem_req = 1'b0; mem_hit = 1'b0; mem_dst = 5'd0;
    wb_dst = 5'd0; wb_wr = 1'b0; br_taken = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic load_use_inputs(input logic [AW-1:0] r);
    id_valid = 1'b1; id_rs_use = 1'b1; id_rs = r;
    ex_valid = 1'b1; ex_wr = 1'b1; ex_memread = 1'b1; ex_dst = r;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [18:0] got;
    do_reset();
    push("reset_dut0", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
    push("reset_dut1", 1'b1, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
    @(negedge CLK);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = e.sel ? obs1 : obs0;
      n_checks++;
      if (got !== e.v) begin
        n_fails++;
        $display("FAIL %s: got %b expected %b", e.name, got, e.v);
      end
    end
    tick();
  endtask

  task automatic test_load_use();
    exp_t e;
    logic [18:0] got;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin
          load_use_inputs(5'd5);
          push("lu_stall", 1'b0, mk(4'b0011, 2'b01, 2'b00, 2'b00, 8'd0, 1'b0));
        end
        1: begin
          ex_valid = 1'b0; ex_wr = 1'b0; ex_memread = 1'b0; ex_dst = 5'd0;
          mem_valid = 1'b1; mem_wr = 1'b1; mem_dst = 5'd5;
          push("lu_single_bubble", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd1, 1'b0));
        end
        default: begin
          mem_valid = 1'b0; mem_wr = 1'b0; mem_dst = 5'd0;
          wb_wr = 1'b1; wb_dst = 5'd5; id_valid = 1'b0;
          push("lu_fwd_memwb", 1'b0, mk(4'b1111, 2'b00, 2'b10, 2'b00, 8'd0, 1'b0));
        end
      endcase
      @(negedge CLK);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = e.sel ? obs1 : obs0;
        n_checks++;
        if (got !== e.v) begin
          n_fails++;
          $display("FAIL %s: got %b expected %b", e.name, got, e.v);
        end
      end
      tick();
    end
  endtask

  task automatic test_fwd_priority();
    exp_t e;
    logic [18:0] got;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin
          id_valid = 1'b1; id_rs_use = 1'b1; id_rs = 5'd3; id_rt_use = 1'b1; id_rt = 5'd7;
          push("fwd_none", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
        end
        1: begin
          mem_valid = 1'b1; mem_wr = 1'b1; mem_dst = 5'd3; wb_wr = 1'b1; wb_dst = 5'd3;
          push("fwd_exmem_priority", 1'b0, mk(4'b1111, 2'b00, 2'b01, 2'b00, 8'd0, 1'b0));
        end
        2: begin
          mem_dst = 5'd0; wb_dst = 5'd0;
          push("fwd_reg0", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
        end
        3: begin
          mem_dst = 5'd4; wb_dst = 5'd7;
          push("fwd_b_memwb", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b10, 8'd0, 1'b0));
        end
        default: begin
          mem_dst = 5'd7; mem_wr = 1'b0; wb_dst = 5'd7;
          push("fwd_wr_gate", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b10, 8'd0, 1'b0));
        end
      endcase
      @(negedge CLK);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = e.sel ? obs1 : obs0;
        n_checks++;
        if (got !== e.v) begin
          n_fails++;
          $display("FAIL %s: got %b expected %b", e.name, got, e.v);
        end
      end
      tick();
    end
  endtask

  task automatic test_miss();
    exp_t e;
    logic [18:0] got;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        mem_req = 1'b1; mem_hit = 1'b0;
        push("miss_freeze", 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, 8'(c), 1'b0));
      end else if (c == 4) begin
        mem_hit = 1'b1;
        push("miss_release", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd4, 1'b0));
      end else begin
        idle();
        push("miss_cnt_clear", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
      end
      @(negedge CLK);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = e.sel ? obs1 : obs0;
        n_checks++;
        if (got !== e.v) begin
          n_fails++;
          $display("FAIL %s: got %b expected %b", e.name, got, e.v);
        end
      end
      tick();
    end
  endtask

  task automatic test_br_loaduse();
    exp_t e;
    logic [18:0] got;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      load_use_inputs(5'd5);
      case (c)
        0: begin
          br_taken = 1'b1;
          push("br_lu_flush2", 1'b0, mk(4'b1111, 2'b11, 2'b00, 2'b00, 8'd0, 1'b0));
          push("br_lu_flush1", 1'b1, mk(4'b1111, 2'b10, 2'b00, 2'b00, 8'd0, 1'b0));
        end
        1: begin
          br_taken = 1'b0;
          push("flush_masked_dut0", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
          push("flush_masked_dut1", 1'b1, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
        end
        default: begin
          br_taken = 1'b0;
          push("flush_back_to_run", 1'b0, mk(4'b0011, 2'b01, 2'b00, 2'b00, 8'd0, 1'b0));
        end
      endcase
      @(negedge CLK);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = e.sel ? obs1 : obs0;
        n_checks++;
        if (got !== e.v) begin
          n_fails++;
          $display("FAIL %s: got %b expected %b", e.name, got, e.v);
        end
      end
      tick();
    end
  endtask

  task automatic test_nofwd();
    exp_t e;
    logic [18:0] got;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin
          id_valid = 1'b1; id_rs_use = 1'b1; id_rs = 5'd3;
          ex_valid = 1'b1; ex_wr = 1'b1; ex_memread = 1'b0; ex_dst = 5'd3;
          push("nofwd_ex_stall", 1'b1, mk(4'b0011, 2'b01, 2'b00, 2'b00, 8'd0, 1'b0));
          push("fwd_alu_no_stall", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
        end
        1: begin
          ex_valid = 1'b0; ex_wr = 1'b0; ex_dst = 5'd0;
          mem_valid = 1'b1; mem_wr = 1'b1; mem_dst = 5'd3;
          push("nofwd_mem_stall", 1'b1, mk(4'b0011, 2'b01, 2'b00, 2'b00, 8'd1, 1'b0));
          push("fwd_alu_exmem", 1'b0, mk(4'b1111, 2'b00, 2'b01, 2'b00, 8'd0, 1'b0));
        end
        2: begin
          mem_valid = 1'b0; mem_wr = 1'b0; mem_dst = 5'd0; wb_wr = 1'b1; wb_dst = 5'd3;
          push("nofwd_release", 1'b1, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd2, 1'b0));
        end
        default: begin
          id_valid = 1'b0;
          push("nofwd_fwd_zero", 1'b1, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
          push("fwd_alu_memwb", 1'b0, mk(4'b1111, 2'b00, 2'b10, 2'b00, 8'd0, 1'b0));
        end
      endcase
      @(negedge CLK);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = e.sel ? obs1 : obs0;
        n_checks++;
        if (got !== e.v) begin
          n_fails++;
          $display("FAIL %s: got %b expected %b", e.name, got, e.v);
        end
      end
      tick();
    end
  endtask

  task automatic test_match_qual();
    exp_t e;
    logic [18:0] got;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      id_valid = 1'b1; ex_valid = 1'b1; ex_wr = 1'b1; ex_memread = 1'b1;
      case (c)
        0: begin
          ex_dst = 5'd9; id_rs = 5'd9; id_rs_use = 1'b0;
          push("use_bit_gate", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
        end
        1: begin
          ex_dst = 5'd0; id_rs = 5'd0; id_rs_use = 1'b1;
          push("reg0_gate", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
        end
        2: begin
          id_rs_use = 1'b0; ex_dst = 5'd9; id_rt = 5'd9; id_rt_use = 1'b1;
          push("lu_rt_stall", 1'b0, mk(4'b0011, 2'b01, 2'b00, 2'b00, 8'd0, 1'b0));
        end
        3: begin
          push("lu_one_bubble", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd1, 1'b0));
        end
        default: begin
          ex_wr = 1'b0;
          push("ex_wr_gate", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
        end
      endcase
      @(negedge CLK);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = e.sel ? obs1 : obs0;
        n_checks++;
        if (got !== e.v) begin
          n_fails++;
          $display("FAIL %s: got %b expected %b", e.name, got, e.v);
        end
      end
      tick();
    end
  endtask

  task automatic test_wdog();
    exp_t e;
    logic [18:0] got;
    do_reset();
    for (int c = 0; c < 23; c++) begin
      if (c < 20) begin
        mem_req = 1'b1; mem_hit = 1'b0;
        push("wdog_stall", 1'b0,
             mk(4'b0000, 2'b00, 2'b00, 2'b00, 8'(c), (c >= 15) ? 1'b1 : 1'b0));
      end else if (c == 20) begin
        mem_hit = 1'b1;
        push("wdog_release", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd20, 1'b1));
      end else if (c == 21) begin
        idle();
        push("wdog_sticky", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b1));
      end else begin
        do_reset();
        push("wdog_reset_clear", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
      end
      @(negedge CLK);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = e.sel ? obs1 : obs0;
        n_checks++;
        if (got !== e.v) begin
          n_fails++;
          $display("FAIL %s: got %b expected %b", e.name, got, e.v);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [18:0] got;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      case (c)
        0: begin
          mem_req = 1'b1; mem_hit = 1'b0;
          push("bw_miss", 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
        end
        1: begin
          br_taken = 1'b1;
          push("bw_br_held", 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, 8'd1, 1'b0));
        end
        2: begin
          br_taken = 1'b0;
          push("bw_wait", 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, 8'd2, 1'b0));
        end
        3: begin
          mem_hit = 1'b1;
          push("bw_held_applied", 1'b0, mk(4'b1111, 2'b11, 2'b00, 2'b00, 8'd3, 1'b0));
        end
        4: begin
          idle();
          push("bw_flush_state", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
        end
        5: begin
          do_reset();
          mem_req = 1'b1; mem_hit = 1'b0;
          push("rst_miss", 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
        end
        6: begin
          br_taken = 1'b1;
          push("rst_br_held", 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, 8'd1, 1'b0));
        end
        7: begin
          br_taken = 1'b0;
          RST = 1'b1;
        end
        8: begin
          RST = 1'b0; mem_req = 1'b1; mem_hit = 1'b1;
          push("rst_abort_stall", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
        end
        9: begin
          mem_hit = 1'b0;
          push("rst_new_miss", 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
        end
        10: begin
          mem_hit = 1'b1;
          push("rst_held_discarded", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd1, 1'b0));
        end
        default: begin
          idle();
          push("rst_run_idle", 1'b0, mk(4'b1111, 2'b00, 2'b00, 2'b00, 8'd0, 1'b0));
        end
      endcase
      @(negedge CLK);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = e.sel ? obs1 : obs0;
        n_checks++;
        if (got !== e.v) begin
          n_fails++;
          $display("FAIL %s: got %b expected %b", e.name, got, e.v);
        end
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (got running, expected done)");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_miss();
    test_br_loaduse();
    test_nofwd();
    test_match_qual();
    test_wdog();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
